// File: rtl/triangle_scan_decoder_pkg.sv
// ============================================================================
// triangle_scan_decoder_pkg : shared types and helpers for the scan decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package triangle_scan_decoder_pkg;

  typedef enum logic [0:0] {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } scan_state_e;

  typedef enum logic [1:0] {
    STEP_UP      = 2'd0,
    STEP_DOWN    = 2'd1,
    STEP_ILLEGAL = 2'd2
  } step_class_e;

  localparam logic [7:0] CODE_MAX = 8'd255;
  localparam logic [7:0] CODE_MIN = 8'd0;

  // Modular difference: 255->0 classifies as UP, the tracker rejects it.
  function automatic step_class_e classify_step(input logic [7:0] prev,
                                                input logic [7:0] cur);
    logic [7:0] delta;
    delta = cur - prev;
    if (delta == 8'd1) begin
      return STEP_UP;
    end else if (delta == 8'hFF) begin
      return STEP_DOWN;
    end else begin
      return STEP_ILLEGAL;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_axis_tracker.sv
// ============================================================================
// scan_axis_tracker : per-axis direction tracking and peak/trough detection
// Rev 1.0
// ============================================================================
`default_nettype none

module scan_axis_tracker
  import triangle_scan_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid_i,
  input  logic [7:0] code_i,
  input  logic       step_err_i,
  output logic [7:0] pos_o,
  output logic       dir_o,
  output logic       have_prev_o,
  output logic       step_legal_o,
  output logic       peak_o,
  output logic       trough_o
);

  logic [7:0]  prev_q;
  logic        dir_q;
  logic        dir_d;
  logic        have_prev_q;
  logic        have_dir_q;
  step_class_e w_step;

  always_comb begin
    w_step       = classify_step(prev_q, code_i);
    step_legal_o = 1'b0;
    peak_o       = 1'b0;
    trough_o     = 1'b0;
    dir_d        = dir_q;
    case (w_step)
      STEP_UP: begin
        dir_d = 1'b1;
        if (prev_q != CODE_MAX) begin
          if (!have_dir_q || dir_q) begin
            step_legal_o = 1'b1;
          end else if (prev_q == CODE_MIN) begin
            step_legal_o = 1'b1;
            trough_o     = 1'b1;
          end
        end
      end
      STEP_DOWN: begin
        dir_d = 1'b0;
        if (prev_q != CODE_MIN) begin
          if (!have_dir_q || !dir_q) begin
            step_legal_o = 1'b1;
          end else if (prev_q == CODE_MAX) begin
            step_legal_o = 1'b1;
            peak_o       = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // step_err_i covers both axes, so a clean step here is still discarded
  // when the other axis misbehaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= 8'd0;
      dir_q       <= 1'b0;
      have_prev_q <= 1'b0;
      have_dir_q  <= 1'b0;
    end else if (sample_valid_i) begin
      prev_q      <= code_i;
      have_prev_q <= 1'b1;
      if (have_prev_q) begin
        if (step_err_i) begin
          have_dir_q <= 1'b0;
        end else begin
          have_dir_q <= 1'b1;
          dir_q      <= dir_d;
        end
      end
    end
  end

  assign pos_o       = prev_q;
  assign dir_o       = dir_q;
  assign have_prev_o = have_prev_q;

endmodule

`default_nettype wire

// File: rtl/triangle_scan_decoder.sv
// ============================================================================
// triangle_scan_decoder : X/Y triangle-scan DAC stream decoder with lock FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module triangle_scan_decoder
  import triangle_scan_decoder_pkg::*;
#(
  parameter int         LOCK_COUNT = 16,
  parameter logic [7:0] Y_PHASE    = 8'd128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [7:0]  xdac_in,
  input  logic [7:0]  ydac_in,
  output logic [7:0]  x_pos,
  output logic [7:0]  y_pos,
  output logic        x_dir,
  output logic        y_dir,
  output logic        x_turn,
  output logic        y_turn,
  output logic        frame_start,
  output logic        locked,
  output logic        phase_err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_count
);

  localparam logic [7:0] c_LOCK_COUNT = 8'(LOCK_COUNT);

  logic [7:0]  w_x_pos, w_y_pos;
  logic        w_x_dir, w_y_dir;
  logic        w_x_have_prev, w_y_have_prev;
  logic        w_x_legal, w_y_legal;
  logic        w_x_peak, w_y_peak;
  logic        w_x_trough, w_y_trough;
  logic        w_eval, w_err, w_ok;
  logic        w_locked, w_frame;
  logic [7:0]  w_cnt_inc;

  scan_state_e state_q, state_d;
  logic [7:0]  step_cnt_q, step_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        phase_err_q, phase_err_d;
  logic        x_turn_q, y_turn_q, frame_q;

  scan_axis_tracker u_x_axis (
    .clk            (clk),
    .reset          (reset),
    .sample_valid_i (sample_valid),
    .code_i         (xdac_in),
    .step_err_i     (w_err),
    .pos_o          (w_x_pos),
    .dir_o          (w_x_dir),
    .have_prev_o    (w_x_have_prev),
    .step_legal_o   (w_x_legal),
    .peak_o         (w_x_peak),
    .trough_o       (w_x_trough)
  );

  scan_axis_tracker u_y_axis (
    .clk            (clk),
    .reset          (reset),
    .sample_valid_i (sample_valid),
    .code_i         (ydac_in),
    .step_err_i     (w_err),
    .pos_o          (w_y_pos),
    .dir_o          (w_y_dir),
    .have_prev_o    (w_y_have_prev),
    .step_legal_o   (w_y_legal),
    .peak_o         (w_y_peak),
    .trough_o       (w_y_trough)
  );

  assign w_eval    = sample_valid & w_x_have_prev & w_y_have_prev;
  assign w_err     = w_eval & ~(w_x_legal & w_y_legal);
  assign w_ok      = w_eval & ~w_err;
  assign w_cnt_inc = (step_cnt_q == 8'hFF) ? step_cnt_q : step_cnt_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACQUIRE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACQUIRE: if (w_ok && (w_cnt_inc == c_LOCK_COUNT)) state_d = ST_LOCKED;
      ST_LOCKED:  if (w_err) state_d = ST_ACQUIRE;
      default:    state_d = ST_ACQUIRE;
    endcase
  end

  always_comb begin
    w_locked = (state_q == ST_LOCKED);
    w_frame  = w_ok & w_locked & w_x_trough;
  end

  // The trough is the previous sample (X = 0), so its Y is the held y_pos.
  always_comb begin
    step_cnt_d  = step_cnt_q;
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;
    phase_err_d = phase_err_q;
    if (w_err) begin
      step_cnt_d = 8'd0;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (w_ok && !w_locked) begin
      step_cnt_d = w_cnt_inc;
    end
    if (w_frame) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (w_y_pos != Y_PHASE) phase_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt_q  <= 8'd0;
      err_cnt_q   <= 8'd0;
      frame_cnt_q <= 16'd0;
      phase_err_q <= 1'b0;
      x_turn_q    <= 1'b0;
      y_turn_q    <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      step_cnt_q  <= step_cnt_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      phase_err_q <= phase_err_d;
      x_turn_q    <= w_ok & (w_x_peak | w_x_trough);
      y_turn_q    <= w_ok & (w_y_peak | w_y_trough);
      frame_q     <= w_frame;
    end
  end

  assign x_pos       = w_x_pos;
  assign y_pos       = w_y_pos;
  assign x_dir       = w_x_dir;
  assign y_dir       = w_y_dir;
  assign x_turn      = x_turn_q;
  assign y_turn      = y_turn_q;
  assign frame_start = frame_q;
  assign locked      = w_locked;
  assign phase_err   = phase_err_q;
  assign err_count   = err_cnt_q;
  assign frame_count = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_triangle_scan_decoder.sv
// ============================================================================
// tb_triangle_scan_decoder : randomized bench against a behavioural scan model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_triangle_scan_decoder;

  localparam int LOCK_COUNT = 16;
  localparam int Y_PHASE    = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [7:0]  xdac_in = 8'd0;
  logic [7:0]  ydac_in = 8'd0;
  logic [7:0]  x_pos, y_pos, err_count;
  logic        x_dir, y_dir, x_turn, y_turn, frame_start, locked, phase_err;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_xpos, m_ypos, m_cnt, m_errc, m_fcnt;
  bit m_have_prev, m_have_dir, m_xdir, m_ydir;
  bit m_xturn, m_yturn, m_frame, m_locked, m_perr;

  always #5 clk = ~clk;

  triangle_scan_decoder #(
    .LOCK_COUNT (LOCK_COUNT),
    .Y_PHASE    (8'(Y_PHASE))
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .xdac_in      (xdac_in),
    .ydac_in      (ydac_in),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .x_dir        (x_dir),
    .y_dir        (y_dir),
    .x_turn       (x_turn),
    .y_turn       (y_turn),
    .frame_start  (frame_start),
    .locked       (locked),
    .phase_err    (phase_err),
    .err_count    (err_count),
    .frame_count  (frame_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int tri_wave(input int n);
    int m;
    m = n % 510;
    return (m < 256) ? m : 510 - m;
  endfunction

  // 0 = illegal, 1 = legal, 2 = legal turnaround
  function automatic int axis_verdict(input int prev, input int cur, input bit have_dir,
                                      input bit dir, output bit nd);
    int d;
    bit up, down;
    d    = (cur - prev + 256) % 256;
    up   = (d == 1);
    down = (d == 255);
    nd   = dir;
    if (!up && !down) return 0;
    nd = up;
    if ((up && prev == 255) || (down && prev == 0)) return 0;
    if (!have_dir || dir == up) return 1;
    if ((up && prev == 0) || (down && prev == 255)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_xpos = 0; m_ypos = 0; m_cnt = 0; m_errc = 0; m_fcnt = 0;
    m_have_prev = 0; m_have_dir = 0; m_xdir = 0; m_ydir = 0;
    m_xturn = 0; m_yturn = 0; m_frame = 0; m_locked = 0; m_perr = 0;
  endtask

  task automatic model_step(input bit v, input int x, input int y);
    int vx, vy;
    bit ndx, ndy;
    m_xturn = 0; m_yturn = 0; m_frame = 0;
    if (!v) return;
    if (!m_have_prev) begin
      m_have_prev = 1; m_xpos = x; m_ypos = y;
      return;
    end
    vx = axis_verdict(m_xpos, x, m_have_dir, m_xdir, ndx);
    vy = axis_verdict(m_ypos, y, m_have_dir, m_ydir, ndy);
    if (vx == 0 || vy == 0) begin
      if (m_errc < 255) m_errc++;
      m_cnt = 0; m_locked = 0; m_have_dir = 0;
    end else begin
      m_xturn = (vx == 2);
      m_yturn = (vy == 2);
      if (m_locked) begin
        if (vx == 2 && ndx) begin
          m_frame = 1;
          m_fcnt  = (m_fcnt + 1) % 65536;
          if (m_ypos != Y_PHASE) m_perr = 1;
        end
      end else begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt == LOCK_COUNT) m_locked = 1;
      end
      m_xdir = ndx; m_ydir = ndy; m_have_dir = 1;
    end
    m_xpos = x; m_ypos = y;
  endtask

  task automatic compare_all();
    check_eq("x_pos", x_pos, m_xpos);
    check_eq("y_pos", y_pos, m_ypos);
    check_eq("x_dir", x_dir, m_xdir);
    check_eq("y_dir", y_dir, m_ydir);
    check_eq("x_turn", x_turn, m_xturn);
    check_eq("y_turn", y_turn, m_yturn);
    check_eq("frame_start", frame_start, m_frame);
    check_eq("locked", locked, m_locked);
    check_eq("phase_err", phase_err, m_perr);
    check_eq("err_count", err_count, m_errc);
    check_eq("frame_count", frame_count, m_fcnt);
  endtask

  task automatic apply(input bit v, input int x, input int y);
    sample_valid = v;
    xdac_in      = 8'(x);
    ydac_in      = 8'(y);
    model_step(v, x, y);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Asynchronous: outputs are checked before any further clock edge.
  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int ix, iy;
    bit v;

    // Generator-style stream, Y in quadrature
    do_reset();
    for (int i = 0; i < 520; i++) begin
      apply(1'b1, tri_wave(i), tri_wave(i + 128));
      if (i == 15)  check_eq("lock_before_17", locked, 0);
      if (i == 16)  check_eq("lock_after_17", locked, 1);
      if (i == 510) check_eq("frame_before_trough", frame_start, 0);
      if (i == 511) check_eq("frame_at_trough", frame_start, 1);
    end
    check_eq("gen_frame_count", frame_count, 1);
    check_eq("gen_phase_err", phase_err, 0);
    check_eq("gen_err_count", err_count, 0);

    // Peak 253,254,255,254,253
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ix = (i < 3) ? 253 + i : 257 - i;
      apply(1'b1, ix, 100 + i);
      if (i == 2) check_eq("peak_no_turn_yet", x_turn, 0);
      if (i == 2) check_eq("peak_dir_up", x_dir, 1);
      if (i == 3) check_eq("peak_turn", x_turn, 1);
      if (i == 4) check_eq("peak_turn_once", x_turn, 0);
      if (i == 4) check_eq("peak_dir_down", x_dir, 0);
    end

    // Illegal X jump while locked, then relock
    do_reset();
    for (int i = 0; i <= 100; i++) apply(1'b1, tri_wave(i), tri_wave(i + 128));
    check_eq("pre_jump_locked", locked, 1);
    apply(1'b1, 102, tri_wave(101 + 128));
    check_eq("jump_err_count", err_count, 1);
    check_eq("jump_unlock", locked, 0);
    for (int k = 0; k < 20; k++) begin
      apply(1'b1, 103 + k, tri_wave(102 + k + 128));
      if (k == 14) check_eq("relock_early", locked, 0);
      if (k == 15) check_eq("relock", locked, 1);
    end

    // 255->0 on X together with a Y jump counts once
    do_reset();
    apply(1'b1, 254, 49);
    apply(1'b1, 255, 50);
    apply(1'b1, 0, 52);
    check_eq("double_err_once", err_count, 1);
    check_eq("wrap_no_turn", x_turn, 0);

    // Y started at 0: phase error at first trough, sticky
    do_reset();
    for (int i = 0; i < 620; i++) begin
      apply(1'b1, tri_wave(i), tri_wave(i));
      if (i == 510) check_eq("phase_before", phase_err, 0);
      if (i == 511) check_eq("phase_set", phase_err, 1);
    end
    check_eq("phase_sticky", phase_err, 1);
    do_reset();
    check_eq("phase_cleared", phase_err, 0);

    // Randomized stream with gaps and occasional jumps
    ix = 0;
    iy = $urandom_range(0, 509);
    for (int c = 0; c < 3000; c++) begin
      v = ($urandom_range(0, 9) != 0);
      if (v) begin
        ix++;
        iy++;
        if ($urandom_range(0, 399) == 0) ix += $urandom_range(2, 300);
        if ($urandom_range(0, 399) == 0) iy += $urandom_range(2, 300);
        apply(1'b1, tri_wave(ix), tri_wave(iy));
      end else begin
        apply(1'b0, $urandom_range(0, 255), $urandom_range(0, 255));
      end
    end

    // Error saturation, then reset mid-frame
    do_reset();
    apply(1'b1, 0, 0);
    for (int i = 0; i < 300; i++) apply(1'b1, ((i + 1) * 5) % 256, (i + 1) % 256);
    check_eq("err_saturated", err_count, 255);
    for (int i = 0; i < 40; i++) apply(1'b1, tri_wave(i), tri_wave(i + 128));
    check_eq("midframe_locked", locked, 1);
    #3;
    do_reset();
    check_eq("reset_err_count", err_count, 0);
    check_eq("reset_x_pos", x_pos, 0);
    check_eq("reset_locked", locked, 0);
    apply(1'b1, 10, 20);
    apply(1'b1, 11, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
